// File: rtl/jtcop_sndlatch_if.sv
// Main-CPU to sound-CPU command channel signals.
// The master side drives writes, reads and the overflow clear; the slave side returns the latch and status.
interface jtcop_sndlatch_if;
    logic       main_we;
    logic [7:0] main_din;
    logic       snd_rd;
    logic       ovf_clr;
    logic [7:0] latch;
    logic       snreq;
    logic       pending;
    logic       full;
    logic       overflow;

    modport master (
        output main_we, main_din, snd_rd, ovf_clr,
        input  latch, snreq, pending, full, overflow
    );

    modport slave (
        input  main_we, main_din, snd_rd, ovf_clr,
        output latch, snreq, pending, full, overflow
    );
endinterface

// File: rtl/jtcop_sndlatch.sv
// Sound command latch/queue between the main 68000 and the sound 6502, re-arming snreq per command.
// Define JTCOP_SNDFIFO_EN for a 2**AW deep queue; otherwise a single overwriting latch as on the arcade board.
module jtcop_sndlatch #(
    parameter int AW  = 2,
    parameter int GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    jtcop_sndlatch_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, REQ, HOLD} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t     state;
    logic       snreq_r;
    logic [3:0] gap_cnt;
    logic       snd_rd_l;
    logic       ack;
    logic       pop;
    logic       push;
    logic       pend_nxt;

    // The 6502 read cycle is over when its latch read strobe falls
    assign ack = snd_rd_l & ~bus.snd_rd;
    assign pop = ack && (state == REQ);

`ifdef JTCOP_SNDFIFO_EN
    localparam int         DEPTH    = 2**AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [7:0]    latch_r;
    logic          ovf_r;

    // A full queue still accepts a byte when the head leaves in the same cycle
    assign push = bus.main_we && ((count != FULL_CNT) || pop);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (AW+1)'(1);
        else if (pop && !push)
            count_nxt = count - (AW+1)'(1);
    end

    assign pend_nxt = (count_nxt != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.main_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            latch_r <= 8'hff;
            ovf_r   <= 1'b0;
        end else begin
            count <= count_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            // latch always shows the head; the last popped byte stays visible once empty
            if (pop) begin
                if (count > (AW+1)'(1))
                    latch_r <= mem[rd_ptr + AW'(1)];
                else if (push)
                    latch_r <= bus.main_din;
            end else if (push && (count == '0)) begin
                latch_r <= bus.main_din;
            end
            if (bus.main_we && !push)
                ovf_r <= 1'b1;
            else if (bus.ovf_clr)
                ovf_r <= 1'b0;
        end
    end

    assign bus.latch    = latch_r;
    assign bus.pending  = (count != '0);
    assign bus.full     = (count == FULL_CNT);
    assign bus.overflow = ovf_r;
`else
    localparam int unused_aw = AW;

    logic [7:0] latch_r;
    logic       pend_r;
    logic       unused_ovf_clr;

    assign unused_ovf_clr = bus.ovf_clr;
    assign push           = bus.main_we;
    assign pend_nxt       = push || (pend_r && !pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_r <= 8'hff;
            pend_r  <= 1'b0;
        end else begin
            if (push)
                latch_r <= bus.main_din;
            pend_r <= pend_nxt;
        end
    end

    assign bus.latch    = latch_r;
    assign bus.pending  = pend_r;
    assign bus.full     = 1'b0;
    assign bus.overflow = 1'b0;
`endif

    // HOLD keeps snreq low long enough for the sound side's edge detector to see it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            snreq_r  <= 1'b0;
            gap_cnt  <= '0;
            snd_rd_l <= 1'b0;
        end else begin
            snd_rd_l <= bus.snd_rd;
            case (state)
                EMPTY: begin
                    if (push) begin
                        state   <= REQ;
                        snreq_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (pop) begin
                        state   <= HOLD;
                        snreq_r <= 1'b0;
                        gap_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= pend_nxt ? REQ : EMPTY;
                        snreq_r <= pend_nxt;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    snreq_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.snreq = snreq_r;
endmodule

// File: tb/tb_jtcop_sndlatch.sv
// Self-checking bench for jtcop_sndlatch; expected latch bytes go through a scoreboard queue.
// Exercises the queue when JTCOP_SNDFIFO_EN is defined, the single overwriting latch otherwise.
module tb_jtcop_sndlatch;
    localparam int AW  = 2;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         errors = 0;
    int         checks = 0;
    int         rises = 0;
    logic       snreq_prev = 1'b0;
    logic [7:0] exp_q [$];

    jtcop_sndlatch_if bus ();

    jtcop_sndlatch #(.AW(AW), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Counts snreq rising edges, i.e. NMIs the sound CPU would take
    always @(negedge clk) begin
        if (bus.snreq && !snreq_prev)
            rises++;
        snreq_prev = bus.snreq;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.main_we  = 1'b1;
        bus.main_din = b;
        tick();
        bus.main_we  = 1'b0;
    endtask

    task automatic read_pulse(input int len);
        bus.snd_rd = 1'b1;
        repeat (len) tick();
        bus.snd_rd = 1'b0;
    endtask

    task automatic wait_req(output int lows, output bit ok);
        lows = 0;
        ok   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus.snreq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            lows++;
        end
    endtask

    task automatic test_reset();
        bus.main_we  = 1'b0;
        bus.main_din = 8'h00;
        bus.snd_rd   = 1'b0;
        bus.ovf_clr  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.latch !== 8'hff) begin errors++; $display("[TB] FAIL reset_latch: got %h expected ff", bus.latch); end
        checks++; if (bus.snreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_snreq: got %b expected 0", bus.snreq); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0", bus.pending); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] exp;
        int         lows;
        write_byte(8'h3a);
        exp_q.push_back(8'h3a);
        checks++; if (bus.snreq !== 1'b1) begin errors++; $display("[TB] FAIL single_snreq: got %b expected 1", bus.snreq); end
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL single_latch: got %h expected %h", bus.latch, exp); end
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("[TB] FAIL single_pending: got %b expected 1", bus.pending); end
        read_pulse(3);
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL single_latch_during_read: got %h expected %h", bus.latch, exp); end
        lows = 0;
        repeat (GAP + 3) begin
            tick();
            if (bus.snreq === 1'b0) lows++;
        end
        checks++; if (lows !== GAP + 3) begin errors++; $display("[TB] FAIL single_low_cycles: got %0d expected %0d", lows, GAP + 3); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL single_pending_after_ack: got %b expected 0", bus.pending); end
        // a read while EMPTY must be ignored
        read_pulse(2);
        repeat (GAP + 2) tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL spurious_pending: got %b expected 0", bus.pending); end
        checks++; if (bus.snreq !== 1'b0) begin errors++; $display("[TB] FAIL spurious_snreq: got %b expected 0", bus.snreq); end
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL spurious_latch: got %h expected %h", bus.latch, exp); end
    endtask

`ifdef JTCOP_SNDFIFO_EN
    task automatic test_back_to_back();
        logic [7:0] exp;
        int         lows;
        bit         ok;
        int         r0;
        r0 = rises;
        write_byte(8'h01); exp_q.push_back(8'h01);
        write_byte(8'h02); exp_q.push_back(8'h02);
        write_byte(8'h03); exp_q.push_back(8'h03);
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL b2b_first_latch: got %h expected %h", bus.latch, exp); end
        for (int k = 0; k < 2; k++) begin
            read_pulse(2);
            wait_req(lows, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout: got no snreq expected snreq=1"); end
            checks++; if (lows !== GAP) begin errors++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", lows, GAP); end
            exp = exp_q.pop_front();
            checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL b2b_latch: got %h expected %h", bus.latch, exp); end
        end
        read_pulse(2);
        repeat (GAP + 2) tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pending: got %b expected 0", bus.pending); end
        checks++; if (rises - r0 !== 3) begin errors++; $display("[TB] FAIL b2b_edges: got %0d expected 3", rises - r0); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        int         lows;
        bit         ok;
        for (int i = 0; i < 4; i++) begin
            write_byte(8'ha0 + 8'(i));
            exp_q.push_back(8'ha0 + 8'(i));
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %b expected 1", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", bus.overflow); end
        write_byte(8'ha4);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", bus.overflow); end
        bus.ovf_clr = 1'b1;
        write_byte(8'ha5);
        bus.ovf_clr = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_clr_vs_write: got %b expected 1", bus.overflow); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", bus.overflow); end
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL ovf_head: got %h expected %h", bus.latch, exp); end
        // full queue plus an ack in the same cycle: the write is accepted
        read_pulse(2);
        write_byte(8'ha6);
        exp_q.push_back(8'ha6);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL full_ack_write_full: got %b expected 1", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_ack_write_ovf: got %b expected 0", bus.overflow); end
        wait_req(lows, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_drain_timeout: got no snreq expected snreq=1"); end
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL ovf_drain_latch: got %h expected %h", bus.latch, exp); end
        for (int i = 0; i < 3; i++) begin
            read_pulse(2);
            wait_req(lows, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_drain_timeout: got no snreq expected snreq=1"); end
            checks++; if (lows !== GAP) begin errors++; $display("[TB] FAIL ovf_drain_gap: got %0d expected %0d", lows, GAP); end
            exp = exp_q.pop_front();
            checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL ovf_drain_latch: got %h expected %h", bus.latch, exp); end
        end
        read_pulse(2);
        repeat (GAP + 2) tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain_pending: got %b expected 0", bus.pending); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain_full: got %b expected 0", bus.full); end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp;
        int         lows;
        bit         ok;
        write_byte(8'h55);
        exp_q.push_back(8'h55);
        checks++; if (bus.snreq !== 1'b1) begin errors++; $display("[TB] FAIL same_snreq: got %b expected 1", bus.snreq); end
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL same_head: got %h expected %h", bus.latch, exp); end
        read_pulse(2);
        write_byte(8'h66);
        exp_q.push_back(8'h66);
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL same_latch: got %h expected %h", bus.latch, exp); end
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("[TB] FAIL same_pending: got %b expected 1", bus.pending); end
        checks++; if (bus.snreq !== 1'b0) begin errors++; $display("[TB] FAIL same_hold: got %b expected 0", bus.snreq); end
        // a read during HOLD is spurious and must not pop
        read_pulse(1);
        wait_req(lows, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL same_timeout: got no snreq expected snreq=1"); end
        checks++; if (lows !== GAP - 2) begin errors++; $display("[TB] FAIL same_gap: got %0d expected %0d", lows, GAP - 2); end
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL same_latch_req: got %h expected %h", bus.latch, exp); end
        read_pulse(2);
        repeat (GAP + 2) tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL same_drain: got %b expected 0", bus.pending); end
    endtask
`else
    task automatic test_overwrite();
        logic [7:0] exp;
        int         r0;
        r0 = rises;
        write_byte(8'h11);
        exp_q.delete(); exp_q.push_back(8'h11);
        write_byte(8'h22);
        exp_q.delete(); exp_q.push_back(8'h22);
        repeat (2) tick();
        checks++; if (rises - r0 !== 1) begin errors++; $display("[TB] FAIL ovw_edges: got %0d expected 1", rises - r0); end
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL ovw_latch: got %h expected %h", bus.latch, exp); end
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("[TB] FAIL ovw_pending: got %b expected 1", bus.pending); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL ovw_full: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovw_overflow: got %b expected 0", bus.overflow); end
        read_pulse(2);
        repeat (GAP + 2) tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL ovw_ack_pending: got %b expected 0", bus.pending); end
        checks++; if (bus.snreq !== 1'b0) begin errors++; $display("[TB] FAIL ovw_ack_snreq: got %b expected 0", bus.snreq); end
        checks++; if (rises - r0 !== 1) begin errors++; $display("[TB] FAIL ovw_edges_after: got %0d expected 1", rises - r0); end
    endtask

    task automatic test_write_in_hold();
        logic [7:0] exp;
        int         lows;
        bit         ok;
        write_byte(8'h33);
        checks++; if (bus.latch !== 8'h33) begin errors++; $display("[TB] FAIL hold_first: got %h expected 33", bus.latch); end
        read_pulse(2);
        tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL hold_pending0: got %b expected 0", bus.pending); end
        write_byte(8'h44);
        exp_q.push_back(8'h44);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("[TB] FAIL hold_pending1: got %b expected 1", bus.pending); end
        checks++; if (bus.snreq !== 1'b0) begin errors++; $display("[TB] FAIL hold_snreq: got %b expected 0", bus.snreq); end
        wait_req(lows, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_timeout: got no snreq expected snreq=1"); end
        checks++; if (lows !== GAP - 2) begin errors++; $display("[TB] FAIL hold_gap: got %0d expected %0d", lows, GAP - 2); end
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL hold_latch: got %h expected %h", bus.latch, exp); end
        read_pulse(2);
        repeat (GAP + 2) tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL hold_drain: got %b expected 0", bus.pending); end
    endtask
`endif

    task automatic test_reset_mid_hold();
        logic [7:0] exp;
`ifdef JTCOP_SNDFIFO_EN
        int         lows;
        bit         ok;
        for (int i = 0; i < 5; i++)
            write_byte(8'hb0 + 8'(i));
        read_pulse(2);
        wait_req(lows, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rsthold_timeout: got no snreq expected snreq=1"); end
        read_pulse(2);
        tick();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_pre_ovf: got %b expected 1", bus.overflow); end
`else
        write_byte(8'h5a);
        read_pulse(2);
        tick();
        write_byte(8'h5b);
`endif
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_pre_pending: got %b expected 1", bus.pending); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.snreq !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_snreq: got %b expected 0", bus.snreq); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_pending: got %b expected 0", bus.pending); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.latch !== 8'hff) begin errors++; $display("[TB] FAIL rsthold_latch: got %h expected ff", bus.latch); end
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        write_byte(8'h9c);
        exp_q.push_back(8'h9c);
        checks++; if (bus.snreq !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_post_snreq: got %b expected 1", bus.snreq); end
        exp = exp_q.pop_front();
        checks++; if (bus.latch !== exp) begin errors++; $display("[TB] FAIL rsthold_post_latch: got %h expected %h", bus.latch, exp); end
        read_pulse(2);
        repeat (GAP + 2) tick();
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_post_drain: got %b expected 0", bus.pending); end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef JTCOP_SNDFIFO_EN
        test_back_to_back();
        test_overflow();
        test_same_cycle();
`else
        test_overwrite();
        test_write_in_hold();
`endif
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
